// File: rtl/store_sequencer_if.sv
// rtl/store_sequencer_if.sv - instruction issue, register-file read and data-memory write bundle for store_sequencer
interface store_sequencer_if #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
);
  logic                    instr_valid;
  logic                    instr_ready;
  logic [SIZE-1:0]         instruction;
  logic                    rf_rd_en;
  logic [4:0]              rf_rs1_addr;
  logic [4:0]              rf_rs2_addr;
  logic [WORDSIZE-1:0]     rf_rs1_data;
  logic [WORDSIZE-1:0]     rf_rs2_data;
  logic                    mem_req;
  logic                    mem_ack;
  logic [WORDSIZE-1:0]     mem_addr;
  logic [WORDSIZE-1:0]     mem_wdata;
  logic [WORDSIZE/8-1:0]   mem_wstrb;

  modport master (
    input  instr_valid, instruction, rf_rs1_data, rf_rs2_data, mem_ack,
    output instr_ready, rf_rd_en, rf_rs1_addr, rf_rs2_addr,
           mem_req, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output instr_valid, instruction, rf_rs1_data, rf_rs2_data, mem_ack,
    input  instr_ready, rf_rd_en, rf_rs1_addr, rf_rs2_addr,
           mem_req, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/store_sequencer.sv
// rtl/store_sequencer.sv - multi-cycle RISC-V S-type store sequencer (optional MISALIGN_CHECK_EN)
module store_sequencer #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  store_sequencer_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                misaligned
);

  localparam int LANES  = WORDSIZE / 8;
  localparam int LANE_W = $clog2(LANES);
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MEM, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          rs1_q, rs1_d;
  logic [4:0]          rs2_q, rs2_d;
  logic [1:0]          size_q, size_d;
  logic [11:0]         imm_q, imm_d;
  logic [WORDSIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORDSIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [LANES-1:0]    mem_wstrb_q, mem_wstrb_d;
  logic                illegal_q, illegal_d;

  logic [WORDSIZE-1:0] imm_ext;
  logic [WORDSIZE-1:0] raw_addr;
  logic [WORDSIZE-1:0] eff_addr;
  logic [3:0]          size_bytes;
  logic [LANE_W-1:0]   size_mask;
  logic [LANES:0]      wide_ones;
  logic [LANES-1:0]    strb_c;
  logic [WORDSIZE-1:0] wdata_c;
  logic                is_store;

  assign is_store = (bus.instruction[6:0] == OPC_STORE) && !bus.instruction[14];

`ifdef MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  logic misalign_hit;
`endif

  always_comb begin
    imm_ext    = {{(WORDSIZE-12){imm_q[11]}}, imm_q};
    raw_addr   = bus.rf_rs1_data + imm_ext;
    size_bytes = 4'd1 << size_q;
    size_mask  = LANE_W'(size_bytes - 4'd1);
`ifdef MISALIGN_CHECK_EN
    eff_addr     = raw_addr;
    misalign_hit = |(raw_addr[LANE_W-1:0] & size_mask);
`else
    // Without the check the access is silently aligned down to its natural size.
    eff_addr = raw_addr & ~WORDSIZE'(size_mask);
`endif
    wide_ones = ((LANES+1)'(1) << size_bytes) - (LANES+1)'(1);
    strb_c    = wide_ones[LANES-1:0] << eff_addr[LANE_W-1:0];
    wdata_c   = '0;
    for (int i = 0; i < LANES; i++) begin
      wdata_c[8*i +: 8] = bus.rf_rs2_data[8*(i & int'(size_mask)) +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    size_d      = size_q;
    imm_d       = imm_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    illegal_d   = 1'b0;
`ifdef MISALIGN_CHECK_EN
    misaligned_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          rs1_d  = bus.instruction[19:15];
          rs2_d  = bus.instruction[24:20];
          size_d = bus.instruction[13:12];
          imm_d  = {bus.instruction[31:25], bus.instruction[11:7]};
          if (is_store) state_d = S_READ;
          else          illegal_d = 1'b1;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
`ifdef MISALIGN_CHECK_EN
        if (misalign_hit) begin
          misaligned_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          mem_addr_d  = eff_addr;
          mem_wdata_d = wdata_c;
          mem_wstrb_d = strb_c;
          state_d     = S_MEM;
        end
`else
        mem_addr_d  = eff_addr;
        mem_wdata_d = wdata_c;
        mem_wstrb_d = strb_c;
        state_d     = S_MEM;
`endif
      end
      S_MEM:   if (bus.mem_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      size_q      <= '0;
      imm_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      size_q      <= size_d;
      imm_q       <= imm_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.rf_rd_en    = (state_q == S_READ);
  assign bus.rf_rs1_addr = rs1_q;
  assign bus.rf_rs2_addr = rs2_q;
  assign bus.mem_req     = (state_q == S_MEM);
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wstrb   = mem_wstrb_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign illegal         = illegal_q;

endmodule

// File: tb/tb_store_sequencer.sv
// tb/tb_store_sequencer.sv - self-checking bench for store_sequencer with a cycle-timeline store model
module tb_store_sequencer;
  localparam int NCYC = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, illegal, misaligned;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  store_sequencer_if #(.WORDSIZE(64), .SIZE(32)) bus ();

  store_sequencer #(.WORDSIZE(64), .SIZE(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle index (cycle n = interval after the n-th rising edge).
  bit          e_ready [NCYC];
  bit          e_busy  [NCYC];
  bit          e_rd    [NCYC];
  bit          e_req   [NCYC];
  bit          e_done  [NCYC];
  bit          e_ill   [NCYC];
  bit          e_mis   [NCYC];
  logic [4:0]  e_rs1a  [NCYC];
  logic [4:0]  e_rs2a  [NCYC];
  logic [63:0] e_addr  [NCYC];
  logic [63:0] e_wdata [NCYC];
  logic [7:0]  e_wstrb [NCYC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                                output logic [63:0] a, output logic [63:0] d,
                                output logic [7:0] s, output bit mis);
    int     sz;
    int     i12;
    longint off;
    int     lane;
    sz  = 1 << ins[13:12];
    i12 = {ins[31:25], ins[11:7]};
    if (i12 >= 2048) i12 = i12 - 4096;
    off = i12;
    a   = r1 + off;
    mis = (a % sz) != 0;
`ifndef MISALIGN_CHECK_EN
    a   = a - (a % sz);
    mis = 0;
`endif
    lane = int'(a % 8);
    s = '0;
    for (int k = 0; k < sz; k++) if (lane + k < 8) s[lane + k] = 1'b1;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = r2[8*(i % sz) +: 8];
  endfunction

  always @(negedge clk) begin
    if (cyc < NCYC) begin
      chk("instr_ready", bus.instr_ready, e_ready[cyc]);
      chk("busy", busy, e_busy[cyc]);
      chk("done", done, e_done[cyc]);
      chk("illegal", illegal, e_ill[cyc]);
      chk("misaligned", misaligned, e_mis[cyc]);
      chk("rf_rd_en", bus.rf_rd_en, e_rd[cyc]);
      chk("mem_req", bus.mem_req, e_req[cyc]);
      if (e_rd[cyc]) begin
        chk("rf_rs1_addr", bus.rf_rs1_addr, e_rs1a[cyc]);
        chk("rf_rs2_addr", bus.rf_rs2_addr, e_rs2a[cyc]);
      end
      if (e_req[cyc]) begin
        chk("mem_addr", bus.mem_addr, e_addr[cyc]);
        chk("mem_wdata", bus.mem_wdata, e_wdata[cyc]);
        chk("mem_wstrb", bus.mem_wstrb, e_wstrb[cyc]);
      end
    end
  end

  // Fills the timeline for a store accepted at the next edge; stall = MEM cycles with ack low.
  task automatic plan_store(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                            input int stall, input bit finish, output int t, output bit mis);
    logic [63:0] a, d;
    logic [7:0]  s;
    model(ins, r1, r2, a, d, s, mis);
    t = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      e_ready[t+k] = 0; e_busy[t+k] = 1;
    end
    e_rd[t] = 1; e_rs1a[t] = ins[19:15]; e_rs2a[t] = ins[24:20];
    if (mis) e_mis[t+2] = 1;
    else begin
      for (int k = 0; k < stall + (finish ? 1 : 0); k++) begin
        e_ready[t+2+k] = 0; e_busy[t+2+k] = 1; e_req[t+2+k] = 1;
        e_addr[t+2+k] = a; e_wdata[t+2+k] = d; e_wstrb[t+2+k] = s;
      end
      if (finish) begin
        e_ready[t+3+stall] = 0; e_busy[t+3+stall] = 1; e_done[t+3+stall] = 1;
      end
    end
  endtask

  // Drives acceptance plus the register-file response; returns in the EXEC+1 cycle.
  task automatic issue(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2, input bit early_ack);
    bus.instruction = ins; bus.instr_valid = 1'b1; bus.mem_ack = early_ack;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0; bus.instruction = $urandom;
    bus.rf_rs1_data = {$urandom, $urandom}; bus.rf_rs2_data = {$urandom, $urandom};
    @(posedge clk); #1;
    bus.rf_rs1_data = r1; bus.rf_rs2_data = r2;
    @(posedge clk); #1;
    bus.rf_rs1_data = {$urandom, $urandom}; bus.rf_rs2_data = {$urandom, $urandom};
  endtask

  task automatic do_store(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2,
                          input int stall, input bit early_ack, input bit lit,
                          input logic [63:0] l_addr, input logic [7:0] l_strb, input logic [63:0] l_data);
    int t;
    bit mis;
    plan_store(ins, r1, r2, stall, 1'b1, t, mis);
    issue(ins, r1, r2, early_ack);
    if (mis) begin
      bus.mem_ack = 1'b0;
    end else begin
      if (lit) begin
        chk("lit_mem_addr", bus.mem_addr, l_addr);
        chk("lit_mem_wstrb", bus.mem_wstrb, l_strb);
        chk("lit_mem_wdata", bus.mem_wdata, l_data);
      end
      for (int k = 0; k <= stall; k++) begin
        bus.mem_ack = (k == stall);
        @(posedge clk); #1;
      end
      chk("lit_done_latency", done, 1'b1);
      bus.mem_ack = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_illegal(input logic [31:0] ins);
    e_ill[cyc + 1] = 1;
    bus.instruction = ins; bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic do_stall_reset(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2, input int stall);
    int t;
    bit mis;
    plan_store(ins, r1, r2, stall, 1'b0, t, mis);
    issue(ins, r1, r2, 1'b0);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 64'h0);
    chk("rst_instr_ready", bus.instr_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
  endtask

  localparam logic [63:0] RS2 = 64'hDEADBEEFCAFEF00D;

  initial begin
    for (int i = 0; i < NCYC; i++) e_ready[i] = 1;
    bus.instr_valid = 1'b0; bus.instruction = '0; bus.mem_ack = 1'b0;
    bus.rf_rs1_data = '0; bus.rf_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_addr", bus.mem_addr, 64'h0);
    chk("reset_mem_wdata", bus.mem_wdata, 64'h0);
    chk("reset_mem_wstrb", bus.mem_wstrb, 8'h0);
    chk("reset_instr_ready", bus.instr_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_store(32'h0020B423, 64'h1000, RS2, 0, 1'b1, 1'b1, 64'h1008, 8'hFF, RS2);
    do_store(32'hFE208FA3, 64'h1000, RS2, 0, 1'b0, 1'b1, 64'h0FFF, 8'h80, 64'h0D0D0D0D0D0D0D0D);
`ifdef MISALIGN_CHECK_EN
    do_store(32'h0020A123, 64'h1000, RS2, 0, 1'b0, 1'b0, 64'h0, 8'h0, 64'h0);
`else
    do_store(32'h0020A123, 64'h1000, RS2, 0, 1'b0, 1'b1, 64'h1000, 8'h0F, 64'hCAFEF00DCAFEF00D);
`endif
    do_illegal(32'h002081B3);
    do_store(32'h0020B423, 64'h2000, RS2, 2, 1'b1, 1'b1, 64'h2008, 8'hFF, RS2);
    do_illegal(32'h0020C423);
    do_store(32'h00209323, 64'h2000, RS2, 3, 1'b0, 1'b1, 64'h2006, 8'hC0, 64'hF00DF00DF00DF00D);
    do_store(32'h0020B423, 64'hFFFFFFFFFFFFFFF8, 64'h0123456789ABCDEF, 0, 1'b0, 1'b1,
             64'h0, 8'hFF, 64'h0123456789ABCDEF);
    do_stall_reset(32'h0020B423, 64'h3000, RS2, 10);
    do_store(32'hFE208FA3, 64'h1000, 64'h00000000000000A5, 1, 1'b0, 1'b1,
             64'h0FFF, 8'h80, 64'hA5A5A5A5A5A5A5A5);
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
